// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and playfield geometry used by
// the shape decoder, display driver and asteroid field scroller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } game_state_e;

    localparam int unsigned ASTEROID_COLS  = 7;
    localparam int unsigned PLAYFIELD_ROWS = 8;

endpackage : game_pkg

// File: rtl/game_tick_gen.sv
// Scroll-step timebase: counts TICK_DIV enabled cycles and pulses tick on the
// last one; clr restarts the count from zero.
module game_tick_gen #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : game_tick_gen

// File: rtl/asteroid_field_scroller.sv
// Scrolls decoder shape rows down a playfield shift register each game tick,
// detects player collisions on the bottom row and keeps a dodge score.
module asteroid_field_scroller
    import game_pkg::*;
#(
    parameter int unsigned COLS     = ASTEROID_COLS,
    parameter int unsigned ROWS     = PLAYFIELD_ROWS,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [COLS-1:0]      shape_in,
    input  logic [2:0]           player_col,
    output logic                 shape_req,
    output logic [ROWS*COLS-1:0] field_out,
    output logic                 running,
    output logic                 crash,
    output logic [SCORE_W-1:0]   score
);

    game_state_e state_q, state_d;
    logic [ROWS*COLS-1:0] field_q, field_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 running_q, running_d;
    logic                 crash_q, crash_d;

    logic [COLS-1:0] bottom_row;
    logic [2:0]      col_idx;
    logic            hit;
    logic            start_go;
    logic            step;

    assign bottom_row = field_q[(ROWS-1)*COLS +: COLS];
    assign col_idx    = (int'(player_col) >= int'(COLS)) ? 3'(COLS - 1) : player_col;
    assign hit        = (state_q == RUN) && bottom_row[col_idx];
    // start is only honoured outside RUN, so it never disturbs a live game's timebase
    assign start_go   = start && (state_q != RUN);

    game_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   ((state_q == RUN) && !hit),
        .clr  (start_go),
        .tick (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            crash_q   <= 1'b0;
            field_q   <= '0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            crash_q   <= crash_d;
            field_q   <= field_d;
            score_q   <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (hit)   state_d = CRASH;
            CRASH:   if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running_d = (state_d == RUN);
        crash_d   = (state_d == CRASH);
        shape_req = step;
    end

    // A hit suppresses step, so the colliding row stays in place and unscored
    always_comb begin
        field_d = field_q;
        score_d = score_q;
        if (start_go) begin
            field_d = '0;
            score_d = '0;
        end else if (step) begin
            field_d = {field_q[(ROWS-1)*COLS-1:0], shape_in};
            if ((bottom_row != '0) && (score_q != '1)) begin
                score_d = score_q + 1'b1;
            end
        end
    end

    assign field_out = field_q;
    assign running   = running_q;
    assign crash     = crash_q;
    assign score     = score_q;

endmodule : asteroid_field_scroller

// File: tb/tb_asteroid_field_scroller.sv
// Directed bench for asteroid_field_scroller with a row-array reference model
// compared on every falling clock edge.
module tb_asteroid_field_scroller;

    localparam int NC = 7;
    localparam int NR = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NC-1:0] shape_in;
    logic [2:0]    player_col;
    logic          shape_req;
    logic [NR*NC-1:0] field_out;
    logic          running;
    logic          crash;
    logic [7:0]    score;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    asteroid_field_scroller #(
        .COLS(NC),
        .ROWS(NR),
        .TICK_DIV(TD),
        .SCORE_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shape_in  (shape_in),
        .player_col(player_col),
        .shape_req (shape_req),
        .field_out (field_out),
        .running   (running),
        .crash     (crash),
        .score     (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 playing, 2 crashed
    int         m_mode;
    int         m_phase;
    int         m_score;
    logic [NC-1:0] m_row [NR];

    function automatic bit m_hit();
        int c;
        c = (int'(player_col) >= NC) ? NC - 1 : int'(player_col);
        return (m_mode == 1) && m_row[NR-1][c];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_score = 0;
            for (int r = 0; r < NR; r++) m_row[r] = '0;
        end else if (start && m_mode != 1) begin
            m_mode = 1; m_phase = 0; m_score = 0;
            for (int r = 0; r < NR; r++) m_row[r] = '0;
        end else if (m_mode == 1) begin
            if (m_hit()) begin
                m_mode = 2;
            end else if (m_phase == TD - 1) begin
                if (m_row[NR-1] != 0 && m_score < 255) m_score++;
                for (int r = NR - 1; r > 0; r--) m_row[r] = m_row[r-1];
                m_row[0] = shape_in;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    always @(negedge clk) begin
        logic [NR*NC-1:0] ef;
        for (int r = 0; r < NR; r++) ef[r*NC +: NC] = m_row[r];
        chk("model_field", field_out, ef);
        chk("model_score", score, m_score);
        chk("model_running", running, m_mode == 1);
        chk("model_crash", crash, m_mode == 2);
        chk("model_shape_req", shape_req, (m_mode == 1) && !m_hit() && (m_phase == TD - 1));
        if (shape_req) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; shape_in = '0; player_col = 3'd0;
        tick(3);
        chk("rst_field", field_out, 0);
        chk("rst_score", score, 0);
        chk("rst_flags", {running, crash, shape_req}, 3'b000);
        rst_n = 1'b1;
        tick(20);
        chk("idle_field", field_out, 0);
        chk("idle_flags", {running, crash, shape_req}, 3'b000);

        // first row enters on the fourth cycle of play
        pulses = 0;
        start = 1'b1; shape_in = 7'b0001000;
        tick(1);
        start = 1'b0;
        chk("start_running", running, 1);
        tick(3);
        chk("step1_req", shape_req, 1);
        tick(1);
        shape_in = '0;
        chk("step1_req_low", shape_req, 0);
        chk("step1_row0", field_out[6:0], 7'b0001000);
        chk("step1_rest", field_out[NR*NC-1:NC], 0);

        tick(TD);
        chk("step2_row1", field_out[13:7], 7'b0001000);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(TD - 1);
        chk("ignore_start_row2", field_out[20:14], 7'b0001000);
        chk("ignore_start_run", running, 1);
        tick(6 * TD);
        chk("step9_score", score, 1);
        chk("step9_field", field_out, 0);
        chk("step9_pulses", pulses, 9);

        // second row, player in its column
        shape_in = 7'b0001000;
        tick(TD);
        shape_in = '0;
        player_col = 3'd3;
        chk("step10_row0", field_out[6:0], 7'b0001000);
        tick(7 * TD);
        chk("row7_set", field_out[55:49], 7'b0001000);
        chk("row7_no_crash_yet", crash, 0);
        tick(1);
        chk("crash_latency", crash, 1);
        chk("crash_not_running", running, 0);
        tick(22);
        chk("frozen_field", field_out, {7'b0001000, 49'b0});
        chk("frozen_score", score, 1);
        chk("frozen_pulses", pulses, 17);
        chk("frozen_req", shape_req, 0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_flags", {running, crash}, 2'b10);
        chk("restart_field", field_out, 0);
        chk("restart_score", score, 0);

        // every row filled with a column-3 rock, player safe in column 0
        player_col = 3'd0;
        shape_in = 7'b0001000;
        tick(11 * TD);
        chk("score3", score, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_field", field_out, 0);
        chk("async_score", score, 0);
        chk("async_flags", {running, crash, shape_req}, 3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_asteroid_field_scroller
